uart_receiver: RTL and testbench
================================

Name: uart_receiver

Overview:
UART receive path: 8N1 frames, LSB first, idle-high line. Bit period is dfv+1 clk cycles, the same encoding used by the UART transmitter. It synchronises the asynchronous uart_rx pin, detects the start bit, mid-bit samples the 8 data bits, and checks the stop bit. Received bytes go to the controller through a valid/ack holding register, with framing and overrun error flags.

Parameters:
SYNC_STAGES, 2, number of flip-flops in the uart_rx synchroniser (legal values 2..4).

Ports:
clk  input  1  clock; all logic on rising edge.
rst  input  1  reset, asynchronous, active-high.
rec_en  input  1  receiver enable; low = synchronous clear to IDLE.
dfv  input  16  divide frequency value; bit period = dfv+1 clk cycles; legal range dfv >= 3.
uart_rx  input  1  UART rx wire, asynchronous.
rx_data  output  8  last good received byte.
rx_valid  output  1  rx_data holds an unread byte (level signal).
rx_ack  input  1  controller has consumed rx_data.
frame_err  output  1  one-cycle pulse: stop bit sampled low.
overrun  output  1  one-cycle pulse: new byte overwrote an unacked byte.

Behaviour:
- Reset (rst=1, async): state=IDLE; counter, bit_counter and shift register = 0; synchroniser flops = 1. Outputs: rx_data=8'h00, rx_valid=0, frame_err=0, overrun=0.
- Synchroniser: rx_s is uart_rx delayed by SYNC_STAGES flops. rx_d is rx_s delayed by one more flop. All logic uses rx_s.
- rec_en=0 (sync): state=IDLE, counters=0, rx_valid=0, error pulses=0, rx_data holds its value. dfv changes are legal only while rec_en=0.
- FSM states: IDLE, START, RECEIVE, STOP.
- IDLE: when rx_d=1 and rx_s=0 (falling edge), go to START with counter=0. A line held low never re-triggers; a new start needs a high level first.
- START: counter increments each cycle. At counter == dfv>>1 (mid start bit), check rx_s:
  - rx_s=1: glitch; return to IDLE with no output.
  - rx_s=0: counter=0, bit_counter=0, go to RECEIVE.
- RECEIVE: counter increments each cycle. When counter >= dfv (mid data bit):
  - shift_reg[bit_counter] <= rx_s; counter=0; bit_counter increments.
  - After the 8th sample (bit_counter reaches 8), go to STOP with counter=0.
- STOP: counter increments each cycle. When counter >= dfv (mid stop bit), go to IDLE and:
  - rx_s=1: on the next edge rx_data <= shift_reg and rx_valid <= 1.
  - rx_s=0: frame_err pulses for one cycle; the byte is discarded; rx_data and rx_valid are unchanged.
- Latency: rx_valid rises on the clock edge after the stop-bit mid-sample. That is about 9.5 bit periods + SYNC_STAGES cycles after the line falling edge.
- Handshake:
  - rx_ack while rx_valid=1: rx_valid clears next cycle.
  - rx_ack while rx_valid=0: ignored.
- New good byte, rx_valid=1, rx_ack=0 in the same cycle: rx_data is overwritten, rx_valid stays 1, overrun pulses for one cycle.
- New good byte and rx_ack in the same cycle: new byte loaded, rx_valid stays 1, no overrun.
- Back-to-back frames: the receiver is in IDLE from mid stop bit onward, so a start edge at the end of the stop bit is caught.
- Counter width is 16 bits. Compares use >= so a dfv decrease cannot cause wrap-around.

Test Plan:
1. dfv=15, SYNC_STAGES=2, drive frame 0xA5 (start, 1,0,1,0,0,1,0,1, stop=1) -> rx_valid rises about 152+2 cycles after the start edge; rx_data=8'hA5; frame_err=0; pulse rx_ack -> rx_valid=0 next cycle.
2. dfv=15, low glitch of 4 cycles on an idle line -> FSM returns to IDLE at the mid-start check; rx_valid, frame_err and overrun all stay 0.
3. dfv=15, frame 0x3C with stop bit driven 0 -> frame_err pulses exactly 1 cycle; rx_valid stays 0; rx_data keeps its previous value. After the line returns high, frame 0x81 -> rx_data=8'h81.
4. dfv=7, frames 0x11 then 0x22 back-to-back with no rx_ack -> after the second frame rx_data=8'h22, rx_valid=1, one overrun pulse. Repeat with rx_ack asserted on the completion cycle -> no overrun.
5. dfv=15, frame 0xFF; drop rec_en for 1 cycle mid-data -> state IDLE; rx_valid=0 and no output for that frame. Following frame 0x00 -> rx_data=8'h00, rx_valid=1.
6. rst asserted asynchronously mid-frame (between clock edges) -> all outputs 0 immediately. After release, frame 0x5A is received correctly.

Source files
------------

// File: rtl/uart_receiver_if.sv
// Byte hand-off between the UART receive path and its controller.
// rx_valid is a level: it stays high while rx_data holds an unread byte; the controller raises
// rx_ack for one cycle to consume it (ack with rx_valid low is ignored). frame_err/overrun are one-cycle pulses.
interface uart_receiver_if;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       rx_ack;
  logic       frame_err;
  logic       overrun;

  modport master (
    output rx_data,
    output rx_valid,
    output frame_err,
    output overrun,
    input  rx_ack
  );

  modport slave (
    input  rx_data,
    input  rx_valid,
    input  frame_err,
    input  overrun,
    output rx_ack
  );
endinterface

// File: rtl/uart_receiver.sv
// 8N1 UART receiver: synchronises the rx pin, mid-bit samples start/data/stop bits with a
// (dfv+1)-cycle bit period, and presents bytes through a valid/ack holding register.
module uart_receiver #(
  parameter int SYNC_STAGES = 2
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               rec_en,
  input  logic [15:0]        dfv,
  input  logic               uart_rx,
  uart_receiver_if.master    rx_bus,
  output logic [1:0]         state_o
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    START   = 2'd1,
    RECEIVE = 2'd2,
    STOP    = 2'd3
  } state_t;

  state_t                 state_q;
  logic [SYNC_STAGES-1:0] sync_q;
  logic                   rx_d_q;
  logic                   rx_s;
  logic [15:0]            cnt_q;
  logic [3:0]             bit_cnt_q;
  logic [7:0]             shift_q;
  logic [7:0]             rx_data_q;
  logic                   rx_valid_q;
  logic                   frame_err_q;
  logic                   overrun_q;
  logic [15:0]            half_dfv;

  assign rx_s     = sync_q[SYNC_STAGES-1];
  assign half_dfv = {1'b0, dfv[15:1]};

  // Synchroniser resets to the idle-high line level so reset release never looks like a start edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_q <= '1;
      rx_d_q <= 1'b1;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], uart_rx};
      rx_d_q <= rx_s;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      cnt_q       <= 16'd0;
      bit_cnt_q   <= 4'd0;
      shift_q     <= 8'h00;
      rx_data_q   <= 8'h00;
      rx_valid_q  <= 1'b0;
      frame_err_q <= 1'b0;
      overrun_q   <= 1'b0;
    end else if (!rec_en) begin
      state_q     <= IDLE;
      cnt_q       <= 16'd0;
      bit_cnt_q   <= 4'd0;
      rx_valid_q  <= 1'b0;
      frame_err_q <= 1'b0;
      overrun_q   <= 1'b0;
    end else begin
      frame_err_q <= 1'b0;
      overrun_q   <= 1'b0;
      if (rx_bus.rx_ack && rx_valid_q) begin
        rx_valid_q <= 1'b0;
      end
      case (state_q)
        IDLE: begin
          if (rx_d_q && !rx_s) begin
            state_q <= START;
            cnt_q   <= 16'd0;
          end
        end
        START: begin
          if (cnt_q >= half_dfv) begin
            if (rx_s) begin
              state_q <= IDLE;
            end else begin
              state_q   <= RECEIVE;
              cnt_q     <= 16'd0;
              bit_cnt_q <= 4'd0;
            end
          end else begin
            cnt_q <= cnt_q + 16'd1;
          end
        end
        RECEIVE: begin
          // >= rather than == keeps a shrunken dfv from letting the counter run off to wrap-around.
          if (cnt_q >= dfv) begin
            shift_q[bit_cnt_q[2:0]] <= rx_s;
            cnt_q                   <= 16'd0;
            bit_cnt_q               <= bit_cnt_q + 4'd1;
            if (bit_cnt_q == 4'd7) begin
              state_q <= STOP;
            end
          end else begin
            cnt_q <= cnt_q + 16'd1;
          end
        end
        STOP: begin
          if (cnt_q >= dfv) begin
            state_q <= IDLE;
            cnt_q   <= 16'd0;
            if (rx_s) begin
              rx_data_q  <= shift_q;
              rx_valid_q <= 1'b1;
              overrun_q  <= rx_valid_q && !rx_bus.rx_ack;
            end else begin
              frame_err_q <= 1'b1;
            end
          end else begin
            cnt_q <= cnt_q + 16'd1;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign rx_bus.rx_data   = rx_data_q;
  assign rx_bus.rx_valid  = rx_valid_q;
  assign rx_bus.frame_err = frame_err_q;
  assign rx_bus.overrun   = overrun_q;
  assign state_o          = state_q;

endmodule

// File: tb/tb_uart_receiver.sv
// Bench for uart_receiver: directed corner sequences, a table of frame vectors, and random
// frames checked against a frame-level model of the receive/hand-off rules.
module tb_uart_receiver;
  localparam int         SYNC    = 2;
  localparam logic [1:0] ST_IDLE = 2'd0;

  logic        clk = 1'b0;
  logic        rst;
  logic        rec_en;
  logic [15:0] dfv;
  logic        uart_rx;
  logic [1:0]  state_o;

  uart_receiver_if rx_bus ();

  uart_receiver #(.SYNC_STAGES(SYNC)) dut (
    .clk     (clk),
    .rst     (rst),
    .rec_en  (rec_en),
    .dfv     (dfv),
    .uart_rx (uart_rx),
    .rx_bus  (rx_bus),
    .state_o (state_o)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- output monitor ----------------
  int   fe_cnt = 0;
  int   ov_cnt = 0;
  int   fe_long = 0;
  int   ov_long = 0;
  int   valid_rise_cyc = -100000;
  logic fe_prev = 1'b0;
  logic ov_prev = 1'b0;
  logic v_prev  = 1'b0;

  always @(negedge clk) begin
    if (rx_bus.frame_err && !fe_prev) fe_cnt <= fe_cnt + 1;
    if (rx_bus.frame_err && fe_prev)  fe_long <= fe_long + 1;
    if (rx_bus.overrun && !ov_prev)   ov_cnt <= ov_cnt + 1;
    if (rx_bus.overrun && ov_prev)    ov_long <= ov_long + 1;
    if (rx_bus.rx_valid && !v_prev)   valid_rise_cyc <= cyc;
    fe_prev <= rx_bus.frame_err;
    ov_prev <= rx_bus.overrun;
    v_prev  <= rx_bus.rx_valid;
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached, got running expected finished");
    $fatal(1, "watchdog");
  end

  // ---------------- scoreboard ----------------
  logic [7:0] exp_q[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic pulse_ack();
    rx_bus.rx_ack = 1'b1;
    @(negedge clk);
    rx_bus.rx_ack = 1'b0;
  endtask

  task automatic set_dfv(input logic [15:0] v);
    rec_en = 1'b0;
    dfv    = v;
    @(negedge clk);
    rec_en = 1'b1;
    @(negedge clk);
  endtask

  task automatic send_frame(input logic [7:0] d, input logic stop_bit);
    int bc;
    bc = int'(dfv) + 1;
    uart_rx = 1'b0;
    repeat (bc) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      uart_rx = d[i];
      repeat (bc) @(negedge clk);
    end
    uart_rx = stop_bit;
    repeat (bc) @(negedge clk);
    uart_rx = 1'b1;
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    logic [7:0] d;
    logic       stop;
    logic       ack;
    logic [7:0] exp_data;
    logic       exp_valid;
    int         exp_fe;
    int         exp_ov;
  } vec_t;

  vec_t vecs[6];

  initial begin
    int fe0, ov0, lat, w, l1;
    logic       m_valid;
    logic [7:0] m_data;

    vecs[0] = '{8'h3C, 1'b0, 1'b0, 8'hA5, 1'b0, 1, 0};
    vecs[1] = '{8'h81, 1'b1, 1'b0, 8'h81, 1'b1, 0, 0};
    vecs[2] = '{8'h5E, 1'b1, 1'b0, 8'h5E, 1'b1, 0, 1};
    vecs[3] = '{8'hC3, 1'b1, 1'b1, 8'hC3, 1'b1, 0, 0};
    vecs[4] = '{8'h00, 1'b0, 1'b0, 8'hC3, 1'b1, 1, 0};
    vecs[5] = '{8'h7E, 1'b1, 1'b1, 8'h7E, 1'b1, 0, 0};

    rst = 1'b1; rec_en = 1'b1; dfv = 16'd15; uart_rx = 1'b1; rx_bus.rx_ack = 1'b0;
    idle(3);
    check("reset_rx_data",   32'(rx_bus.rx_data),   32'h00);
    check("reset_rx_valid",  32'(rx_bus.rx_valid),  32'h0);
    check("reset_frame_err", 32'(rx_bus.frame_err), 32'h0);
    check("reset_overrun",   32'(rx_bus.overrun),   32'h0);
    check("reset_state",     32'(state_o),          32'(ST_IDLE));
    rst = 1'b0;
    idle(5);

    // Test 1: basic frame, latency and ack
    fe0 = fe_cnt; ov0 = ov_cnt;
    lat = cyc;
    send_frame(8'hA5, 1'b1);
    w = 0;
    while (!rx_bus.rx_valid && w < 40) begin
      @(negedge clk);
      w++;
    end
    lat = valid_rise_cyc - lat;
    check("t1_valid",          32'(rx_bus.rx_valid), 32'h1);
    check("t1_latency_window", 32'(lat >= 148 && lat <= 162), 32'h1);
    check("t1_data",           32'(rx_bus.rx_data), 32'hA5);
    check("t1_no_frame_err",   32'(fe_cnt - fe0), 32'h0);
    pulse_ack();
    check("t1_ack_clears_valid", 32'(rx_bus.rx_valid), 32'h0);
    check("t1_data_held",        32'(rx_bus.rx_data), 32'hA5);
    pulse_ack();
    check("t1_ack_when_empty",   32'(rx_bus.rx_valid), 32'h0);

    // Test 2: short low glitch on an idle line
    fe0 = fe_cnt; ov0 = ov_cnt;
    uart_rx = 1'b0;
    idle(4);
    uart_rx = 1'b1;
    idle(40);
    check("t2_state_idle", 32'(state_o),          32'(ST_IDLE));
    check("t2_no_valid",   32'(rx_bus.rx_valid),  32'h0);
    check("t2_no_fe",      32'(fe_cnt - fe0),     32'h0);
    check("t2_no_ov",      32'(ov_cnt - ov0),     32'h0);

    // Table-driven frames at dfv=15
    foreach (vecs[i]) begin
      if (vecs[i].ack) pulse_ack();
      fe0 = fe_cnt; ov0 = ov_cnt;
      send_frame(vecs[i].d, vecs[i].stop);
      idle(32);
      check($sformatf("vec%0d_data", i),  32'(rx_bus.rx_data),  32'(vecs[i].exp_data));
      check($sformatf("vec%0d_valid", i), 32'(rx_bus.rx_valid), 32'(vecs[i].exp_valid));
      check($sformatf("vec%0d_fe", i),    32'(fe_cnt - fe0),    32'(vecs[i].exp_fe));
      check($sformatf("vec%0d_ov", i),    32'(ov_cnt - ov0),    32'(vecs[i].exp_ov));
    end

    // Test 4a: back-to-back frames with no ack
    set_dfv(16'd7);
    ov0 = ov_cnt;
    send_frame(8'h11, 1'b1);
    send_frame(8'h22, 1'b1);
    idle(16);
    check("t4a_data",    32'(rx_bus.rx_data),  32'h22);
    check("t4a_valid",   32'(rx_bus.rx_valid), 32'h1);
    check("t4a_overrun", 32'(ov_cnt - ov0),    32'h1);

    // Test 4b: ack lands on the completion cycle of the second frame
    pulse_ack();
    ov0 = ov_cnt;
    l1 = cyc;
    send_frame(8'h11, 1'b1);
    l1 = valid_rise_cyc - l1;
    fork
      send_frame(8'h22, 1'b1);
      begin
        repeat (l1 - 1) @(negedge clk);
        rx_bus.rx_ack = 1'b1;
        @(negedge clk);
        rx_bus.rx_ack = 1'b0;
      end
    join
    idle(16);
    check("t4b_data",       32'(rx_bus.rx_data),  32'h22);
    check("t4b_valid",      32'(rx_bus.rx_valid), 32'h1);
    check("t4b_no_overrun", 32'(ov_cnt - ov0),    32'h0);

    // Test 5: rec_en dropped mid-frame
    set_dfv(16'd15);
    fork
      send_frame(8'hFF, 1'b1);
      begin
        idle(60);
        rec_en = 1'b0;
        @(negedge clk);
        check("t5_state_idle_on_disable", 32'(state_o), 32'(ST_IDLE));
        rec_en = 1'b1;
      end
    join
    idle(32);
    check("t5_no_valid",  32'(rx_bus.rx_valid), 32'h0);
    check("t5_data_kept", 32'(rx_bus.rx_data),  32'h22);
    send_frame(8'h00, 1'b1);
    idle(32);
    check("t5_next_data",  32'(rx_bus.rx_data),  32'h00);
    check("t5_next_valid", 32'(rx_bus.rx_valid), 32'h1);

    // Test 6: asynchronous reset mid-frame
    pulse_ack();
    send_frame(8'h77, 1'b1);
    idle(32);
    check("t6_pre_data", 32'(rx_bus.rx_data), 32'h77);
    fork
      send_frame(8'hFF, 1'b1);
      begin
        idle(40);
        #2 rst = 1'b1;
        #1;
        check("t6_rst_data",  32'(rx_bus.rx_data),   32'h00);
        check("t6_rst_valid", 32'(rx_bus.rx_valid),  32'h0);
        check("t6_rst_fe",    32'(rx_bus.frame_err), 32'h0);
        check("t6_rst_ov",    32'(rx_bus.overrun),   32'h0);
        check("t6_rst_state", 32'(state_o),          32'(ST_IDLE));
        idle(3);
        rst = 1'b0;
      end
    join
    idle(32);
    send_frame(8'h5A, 1'b1);
    idle(32);
    check("t6_after_data",  32'(rx_bus.rx_data),  32'h5A);
    check("t6_after_valid", 32'(rx_bus.rx_valid), 32'h1);

    // Random frames against the frame-level model
    exp_q.push_back(8'h5A);
    m_valid = 1'b1;
    set_dfv(16'($urandom_range(7, 24)));
    m_valid = 1'b0;
    for (int n = 0; n < 30; n++) begin
      logic [7:0] d;
      logic       stp;
      logic       ack;
      int         e_fe, e_ov;
      d   = 8'($urandom_range(0, 255));
      stp = ($urandom_range(0, 9) != 0);
      ack = 1'($urandom_range(0, 1));
      if (ack) begin
        pulse_ack();
        m_valid = 1'b0;
      end
      e_fe = 0; e_ov = 0;
      if (stp) begin
        e_ov = m_valid ? 1 : 0;
        m_valid = 1'b1;
        exp_q.push_back(d);
      end else begin
        e_fe = 1;
      end
      m_data = exp_q[$];
      fe0 = fe_cnt; ov0 = ov_cnt;
      send_frame(d, stp);
      check($sformatf("rnd%0d_data", n),  32'(rx_bus.rx_data),  32'(m_data));
      check($sformatf("rnd%0d_valid", n), 32'(rx_bus.rx_valid), 32'(m_valid));
      check($sformatf("rnd%0d_fe", n),    32'(fe_cnt - fe0),    32'(e_fe));
      check($sformatf("rnd%0d_ov", n),    32'(ov_cnt - ov0),    32'(e_ov));
      idle($urandom_range(2, 8));
    end

    check("pulse_width_frame_err", 32'(fe_long), 32'h0);
    check("pulse_width_overrun",   32'(ov_long), 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
